muldiv_ctrl: RTL and testbench

Iterative multiply/divide sequencer owning the HI/LO register pair of the pipelined MIPS core. It accepts MULT/MULTU/DIV/DIVU from the EX stage, runs a 32-iteration radix-2 shift-add / restoring-divide loop over one shared adder, and applies signed pre- and post-correction. It exposes `busy` so the hazard logic stalls MFHI/MFLO and any further mul/div until the result is committed.

---
 rtl/muldiv_pkg.sv | 17 +
 rtl/muldiv_step.sv | 84 ++++++++
 rtl/muldiv_ctrl.sv | 231 +++++++++++++++++++++++
 tb/tb_muldiv_ctrl.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared encodings, state type and iteration count for the multiply/divide sequencer.
package muldiv_pkg;

    localparam int MULDIV_ITERS = 32;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_FIX  = 2'b10
    } muldiv_state_e;

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration over a single shared adder: shift-add multiply or restoring divide.
// The divide path exists only when MULDIV_DIV_EN is defined.
module muldiv_step #(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] acc,
    input  logic [DATA_W-1:0] opw,
    input  logic [DATA_W-1:0] mcand,
`ifdef MULDIV_DIV_EN
    input  logic              div_mode,
`endif
    output logic [DATA_W-1:0] acc_nxt,
    output logic [DATA_W-1:0] opw_nxt
);

`ifdef MULDIV_DIV_EN
    // Two guard bits: one for the shifted-in remainder bit, one for the borrow.
    localparam int AW = DATA_W + 2;

    logic [AW-1:0] a_s;
    logic [AW-1:0] b_s;
    logic          cin_s;
    logic [AW-1:0] sum_s;

    // Adder operand selection: trial subtract of the divisor or gated multiplicand.
    always_comb begin
        a_s   = {AW{1'b0}};
        b_s   = {AW{1'b0}};
        cin_s = 1'b0;
        if (div_mode) begin
            a_s   = {1'b0, acc, opw[DATA_W-1]};
            b_s   = ~{2'b00, mcand};
            cin_s = 1'b1;
        end else begin
            a_s = {2'b00, acc};
            if (opw[0]) begin
                b_s = {2'b00, mcand};
            end else begin
                b_s = {AW{1'b0}};
            end
            cin_s = 1'b0;
        end
    end

    assign sum_s = a_s + b_s + {{(AW-1){1'b0}}, cin_s};

    // Next-state selection; a negative trial result restores the shifted remainder.
    always_comb begin
        acc_nxt = acc;
        opw_nxt = opw;
        if (div_mode) begin
            if (sum_s[AW-1]) begin
                acc_nxt = a_s[DATA_W-1:0];
                opw_nxt = {opw[DATA_W-2:0], 1'b0};
            end else begin
                acc_nxt = sum_s[DATA_W-1:0];
                opw_nxt = {opw[DATA_W-2:0], 1'b1};
            end
        end else begin
            acc_nxt = sum_s[DATA_W:1];
            opw_nxt = {sum_s[0], opw[DATA_W-1:1]};
        end
    end
`else
    localparam int AW = DATA_W + 1;

    logic [AW-1:0] b_s;
    logic [AW-1:0] sum_s;

    // Multiplicand gated by the current multiplier bit.
    always_comb begin
        if (opw[0]) begin
            b_s = {1'b0, mcand};
        end else begin
            b_s = {AW{1'b0}};
        end
    end

    assign sum_s   = {1'b0, acc} + b_s;
    assign acc_nxt = sum_s[DATA_W:1];
    assign opw_nxt = {sum_s[0], opw[DATA_W-1:1]};
`endif

endmodule

// File: rtl/muldiv_ctrl.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer owning the HI/LO pair; stalls hazards via busy.
// Define MULDIV_DIV_EN to build the divide datapath; otherwise divides commit 0/0 at once.
module muldiv_ctrl
    import muldiv_pkg::*;
#(
    parameter int DATA_W = MULDIV_ITERS
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [DATA_W-1:0] rs_val,
    input  logic [DATA_W-1:0] rt_val,
    input  logic              flush,
    input  logic              mthi,
    input  logic              mtlo,
    input  logic [DATA_W-1:0] wdata,
    output logic              busy,
    output logic              done,
    output logic              div_by_zero,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo
);

    localparam int                  CNT_W    = $clog2(DATA_W);
    localparam logic [CNT_W-1:0]    CNT_INIT = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0]    CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]    CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [DATA_W-1:0]   ZERO_W   = {DATA_W{1'b0}};
    localparam logic [DATA_W-1:0]   ONE_W    = {{(DATA_W-1){1'b0}}, 1'b1};
    localparam logic [2*DATA_W-1:0] ONE_P    = {{(2*DATA_W-1){1'b0}}, 1'b1};

    function automatic logic [DATA_W-1:0] neg_w(input logic [DATA_W-1:0] x);
        return (~x) + ONE_W;
    endfunction

    function automatic logic [DATA_W-1:0] mag_w(input logic [DATA_W-1:0] x, input logic sgn);
        if (sgn && x[DATA_W-1]) begin
            return neg_w(x);
        end else begin
            return x;
        end
    endfunction

    muldiv_state_e       state_r;
    logic                is_div_r;
    logic [DATA_W-1:0]   acc_r;
    logic [DATA_W-1:0]   opw_r;
    logic [DATA_W-1:0]   mcand_r;
    logic [CNT_W-1:0]    cnt_r;
    logic                neg_lo_r;
    logic [DATA_W-1:0]   hi_r;
    logic [DATA_W-1:0]   lo_r;
    logic                busy_r;
    logic                done_r;
    logic                dbz_flag_r;
`ifdef MULDIV_DIV_EN
    logic                neg_hi_r;
    logic                dbz_r;
    logic [DATA_W-1:0]   dividend_r;
    logic                rt_zero_s;
`endif

    logic                launch_s;
    logic                sgn_op_s;
    logic                is_div_op_s;
    logic                skip_run_s;
    logic [DATA_W-1:0]   acc_nxt_s;
    logic [DATA_W-1:0]   opw_nxt_s;
    logic [2*DATA_W-1:0] prod_s;
    logic [2*DATA_W-1:0] prod_fix_s;
    logic [DATA_W-1:0]   hi_fix_s;
    logic [DATA_W-1:0]   lo_fix_s;
    logic                dbz_fix_s;

    assign sgn_op_s    = (op == OP_MULT) || (op == OP_DIV);
    assign is_div_op_s = (op == OP_DIV) || (op == OP_DIVU);
    // A committing FIX cycle also accepts the next op so back-to-back ops lose no cycle.
    assign launch_s    = start && !flush && ((state_r == ST_IDLE) || (state_r == ST_FIX));
`ifdef MULDIV_DIV_EN
    assign rt_zero_s   = (rt_val == ZERO_W);
    assign skip_run_s  = is_div_op_s && rt_zero_s;
`else
    assign skip_run_s  = is_div_op_s;
`endif

    muldiv_step #(
        .DATA_W (DATA_W)
    ) u_step (
        .acc      (acc_r),
        .opw      (opw_r),
        .mcand    (mcand_r),
`ifdef MULDIV_DIV_EN
        .div_mode (is_div_r),
`endif
        .acc_nxt  (acc_nxt_s),
        .opw_nxt  (opw_nxt_s)
    );

    // Sign correction and special-case results presented at commit.
    always_comb begin
        prod_s = {acc_r, opw_r};
        if (neg_lo_r) begin
            prod_fix_s = (~prod_s) + ONE_P;
        end else begin
            prod_fix_s = prod_s;
        end
        hi_fix_s  = prod_fix_s[2*DATA_W-1:DATA_W];
        lo_fix_s  = prod_fix_s[DATA_W-1:0];
        dbz_fix_s = 1'b0;
        if (is_div_r) begin
`ifdef MULDIV_DIV_EN
            if (dbz_r) begin
                hi_fix_s  = dividend_r;
                lo_fix_s  = {DATA_W{1'b1}};
                dbz_fix_s = 1'b1;
            end else begin
                if (neg_hi_r) begin
                    hi_fix_s = neg_w(acc_r);
                end else begin
                    hi_fix_s = acc_r;
                end
                if (neg_lo_r) begin
                    lo_fix_s = neg_w(opw_r);
                end else begin
                    lo_fix_s = opw_r;
                end
                dbz_fix_s = 1'b0;
            end
`else
            hi_fix_s  = ZERO_W;
            lo_fix_s  = ZERO_W;
            dbz_fix_s = 1'b0;
`endif
        end else begin
            hi_fix_s  = prod_fix_s[2*DATA_W-1:DATA_W];
            lo_fix_s  = prod_fix_s[DATA_W-1:0];
            dbz_fix_s = 1'b0;
        end
    end

    // Sequencer FSM with HI/LO ownership and registered status outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            is_div_r   <= 1'b0;
            acc_r      <= ZERO_W;
            opw_r      <= ZERO_W;
            mcand_r    <= ZERO_W;
            cnt_r      <= CNT_ZERO;
            neg_lo_r   <= 1'b0;
            hi_r       <= ZERO_W;
            lo_r       <= ZERO_W;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            dbz_flag_r <= 1'b0;
`ifdef MULDIV_DIV_EN
            neg_hi_r   <= 1'b0;
            dbz_r      <= 1'b0;
            dividend_r <= ZERO_W;
`endif
        end else begin
            done_r     <= 1'b0;
            dbz_flag_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    busy_r <= 1'b0;
                    if (!start) begin
                        if (mthi) begin
                            hi_r <= wdata;
                        end
                        if (mtlo) begin
                            lo_r <= wdata;
                        end
                    end
                end
                ST_RUN: begin
                    if (flush) begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end else begin
                        acc_r <= acc_nxt_s;
                        opw_r <= opw_nxt_s;
                        if (cnt_r == CNT_ZERO) begin
                            state_r <= ST_FIX;
                        end else begin
                            cnt_r <= cnt_r - CNT_ONE;
                        end
                    end
                end
                ST_FIX: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                    if (!flush) begin
                        hi_r       <= hi_fix_s;
                        lo_r       <= lo_fix_s;
                        done_r     <= 1'b1;
                        dbz_flag_r <= dbz_fix_s;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase

            if (launch_s) begin
                is_div_r <= is_div_op_s;
                acc_r    <= ZERO_W;
                opw_r    <= mag_w(rs_val, sgn_op_s);
                mcand_r  <= mag_w(rt_val, sgn_op_s);
                cnt_r    <= CNT_INIT;
                neg_lo_r <= sgn_op_s && (rs_val[DATA_W-1] ^ rt_val[DATA_W-1]);
                busy_r   <= 1'b1;
                state_r  <= skip_run_s ? ST_FIX : ST_RUN;
`ifdef MULDIV_DIV_EN
                neg_hi_r   <= sgn_op_s && rs_val[DATA_W-1];
                dbz_r      <= skip_run_s;
                dividend_r <= rs_val;
`endif
            end
        end
    end

    assign busy        = busy_r;
    assign done        = done_r;
    assign div_by_zero = dbz_flag_r;
    assign hi          = hi_r;
    assign lo          = lo_r;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: vector table, random ops and corner sequences.
// Divide expectations follow MULDIV_DIV_EN.
module tb_muldiv_ctrl;
    import muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        flush;
    logic        mthi;
    logic        mtlo;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    muldiv_ctrl #(.DATA_W(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .op          (op),
        .rs_val      (rs_val),
        .rt_val      (rt_val),
        .flush       (flush),
        .mthi        (mthi),
        .mtlo        (mtlo),
        .wdata       (wdata),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .hi          (hi),
        .lo          (lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
    } vec_t;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic vec_t mk(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] h, input logic [31:0] l, input logic z);
        vec_t v;
        v.op = o; v.rs = a; v.rt = b; v.hi = h; v.lo = l; v.dbz = z;
`ifndef MULDIV_DIV_EN
        if (o[1]) begin
            v.hi = 32'd0; v.lo = 32'd0; v.dbz = 1'b0;
        end
`endif
        return v;
    endfunction

    // Reference arithmetic done in 64-bit integers.
    function automatic exp_t model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        exp_t        r;
        longint      sa;
        longint      sb;
        logic [63:0] p;
        logic [63:0] ua;
        logic [63:0] ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        r.hi = 32'd0; r.lo = 32'd0; r.dbz = 1'b0;
        case (o)
            OP_MULT:  begin p = sa * sb; r.hi = p[63:32]; r.lo = p[31:0]; end
            OP_MULTU: begin p = ua * ub; r.hi = p[63:32]; r.lo = p[31:0]; end
            default: begin
`ifdef MULDIV_DIV_EN
                if (b == 32'd0) begin
                    r.hi = a; r.lo = 32'hFFFF_FFFF; r.dbz = 1'b1;
                end else if (o == OP_DIV) begin
                    p = sa / sb; r.lo = p[31:0];
                    p = sa % sb; r.hi = p[31:0];
                end else begin
                    p = ua / ub; r.lo = p[31:0];
                    p = ua % ub; r.hi = p[31:0];
                end
`endif
            end
        endcase
        return r;
    endfunction

    function automatic int lat_of(input logic [1:0] o, input logic [31:0] b);
        if (!o[1]) return 33;
`ifdef MULDIV_DIV_EN
        return (b == 32'd0) ? 1 : 33;
`else
        return 1;
`endif
    endfunction

    // Scoreboard: every done pops the oldest expected result.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && done === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 64'd1, 64'd0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("sb_hi", hi, mon_e.hi);
                chk("sb_lo", lo, mon_e.lo);
                chk("sb_dbz", div_by_zero, mon_e.dbz);
            end
        end
    end

    // Called at a negedge; 'already' cycles since the accept edge have elapsed.
    task automatic wait_done(input string name, input int already, input int lat);
        int cyc;
        cyc = already;
        do begin
            @(negedge clk);
            cyc++;
        end while (done !== 1'b1 && cyc < 100);
        chk({name, "_latency"}, cyc, lat);
        chk({name, "_busy_off"}, busy, 64'd0);
        @(negedge clk);
        chk({name, "_done_pulse"}, done, 64'd0);
    endtask

    task automatic do_op(input string name, input logic [1:0] o, input logic [31:0] a,
                         input logic [31:0] b, input exp_t e);
        op = o; rs_val = a; rt_val = b; start = 1'b1;
        exp_q.push_back(e);
        @(negedge clk);
        start = 1'b0;
        chk({name, "_busy_on"}, busy, 64'd1);
        wait_done(name, 0, lat_of(o, b));
    endtask

    task automatic count_no_done(input string name, input int cycles);
        int n;
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (done === 1'b1) n++;
        end
        chk(name, n, 64'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t        tbl[14];
        exp_t        e;
        logic [1:0]  ro;
        logic [31:0] ra;
        logic [31:0] rb;

        rst_n = 1'b0; start = 1'b0; op = 2'b00; rs_val = 32'd0; rt_val = 32'd0;
        flush = 1'b0; mthi = 1'b0; mtlo = 1'b0; wdata = 32'd0;

        tbl[0]  = mk(OP_MULT,  32'hFFFF_FFFE, 32'd3,        32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b0);
        tbl[1]  = mk(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
        tbl[2]  = mk(OP_MULT,  32'd7,         32'hFFFF_FFFB, 32'hFFFF_FFFF, 32'hFFFF_FFDD, 1'b0);
        tbl[3]  = mk(OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0);
        tbl[4]  = mk(OP_MULTU, 32'h1234_5678, 32'h10,        32'h0000_0001, 32'h2345_6780, 1'b0);
        tbl[5]  = mk(OP_MULT,  32'd0,         32'hFFFF_FFFF, 32'd0,         32'd0,         1'b0);
        tbl[6]  = mk(OP_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        tbl[7]  = mk(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 1'b0);
        tbl[8]  = mk(OP_DIVU,  32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF, 1'b1);
        tbl[9]  = mk(OP_DIVU,  32'd100,       32'd7,         32'd2,         32'd14,        1'b0);
        tbl[10] = mk(OP_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 1'b0);
        tbl[11] = mk(OP_DIV,   32'hFFFF_FFF7, 32'd0,         32'hFFFF_FFF7, 32'hFFFF_FFFF, 1'b1);
        tbl[12] = mk(OP_DIVU,  32'hFFFF_FFFF, 32'd1,         32'd0,         32'hFFFF_FFFF, 1'b0);
        tbl[13] = mk(OP_MULT,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0,         32'd1,         1'b0);

        repeat (3) @(negedge clk);
        chk("rst_hi", hi, 64'd0);
        chk("rst_lo", lo, 64'd0);
        chk("rst_busy", busy, 64'd0);
        chk("rst_done", done, 64'd0);
        chk("rst_dbz", div_by_zero, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 14; i++) begin
            e.hi = tbl[i].hi; e.lo = tbl[i].lo; e.dbz = tbl[i].dbz;
            do_op($sformatf("vec%0d", i), tbl[i].op, tbl[i].rs, tbl[i].rt, e);
        end

        for (int i = 0; i < 10; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = ($urandom_range(0, 5) == 0) ? 32'd0 : (32'($urandom) >> $urandom_range(0, 31));
            do_op($sformatf("rnd%0d", i), ro, ra, rb, model(ro, ra, rb));
        end

        // Back-to-back: second op accepted on the commit edge of the first.
        op = OP_MULTU; rs_val = 32'hFFFF_FFFF; rt_val = 32'hFFFF_FFFF; start = 1'b1;
        e.hi = 32'hFFFF_FFFE; e.lo = 32'h0000_0001; e.dbz = 1'b0;
        exp_q.push_back(e);
        @(negedge clk);
        start = 1'b0;
        repeat (32) @(negedge clk);
        chk("b2b_no_early_done", done, 64'd0);
        op = OP_MULT; rs_val = 32'hFFFF_FFFE; rt_val = 32'd3; start = 1'b1;
        e.hi = 32'hFFFF_FFFF; e.lo = 32'hFFFF_FFFA; e.dbz = 1'b0;
        exp_q.push_back(e);
        @(negedge clk);
        start = 1'b0;
        chk("b2b_first_done", done, 64'd1);
        chk("b2b_busy_kept", busy, 64'd1);
        wait_done("b2b_second", 33, 66);

        // A start pulse while busy must not disturb the running op.
        op = OP_MULT; rs_val = 32'd6; rt_val = 32'd7; start = 1'b1;
        e.hi = 32'd0; e.lo = 32'd42; e.dbz = 1'b0;
        exp_q.push_back(e);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        op = OP_DIVU; rs_val = 32'd5; rt_val = 32'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("start_while_busy", 5, 33);

        // Direct HI/LO writes in IDLE.
        mtlo = 1'b1; wdata = 32'h5A5A_0000;
        @(negedge clk);
        mtlo = 1'b0;
        chk("mtlo_idle", lo, 64'h5A5A_0000);
        mthi = 1'b1; wdata = 32'h1111_2222;
        @(negedge clk);
        mthi = 1'b0;
        chk("mthi_idle", hi, 64'h1111_2222);

        // Flush mid-run; an MTHI during busy is dropped.
        op = OP_MULT; rs_val = 32'd3; rt_val = 32'd4; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        mthi = 1'b1; wdata = 32'h0000_1234;
        @(negedge clk);
        mthi = 1'b0;
        repeat (7) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_busy", busy, 64'd0);
        chk("flush_hi_kept", hi, 64'h1111_2222);
        chk("flush_lo_kept", lo, 64'h5A5A_0000);
        count_no_done("flush_no_done", 40);
        mthi = 1'b1; wdata = 32'h0000_1234;
        @(negedge clk);
        mthi = 1'b0;
        chk("mthi_after_flush", hi, 64'h0000_1234);

        // Reset in the middle of an op clears HI/LO and suppresses done.
`ifdef MULDIV_DIV_EN
        op = OP_DIVU; rs_val = 32'd100; rt_val = 32'd7;
`else
        op = OP_MULT; rs_val = 32'd9; rt_val = 32'd9;
`endif
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (19) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_busy", busy, 64'd0);
        chk("midrst_hi", hi, 64'd0);
        chk("midrst_lo", lo, 64'd0);
        chk("midrst_done", done, 64'd0);
        rst_n = 1'b1;
        count_no_done("midrst_no_done", 40);

        // start and mtlo together: the write is dropped and the op runs.
        op = OP_MULTU; rs_val = 32'd2; rt_val = 32'd3; start = 1'b1;
        mtlo = 1'b1; wdata = 32'hDEAD_BEEF;
        e.hi = 32'd0; e.lo = 32'd6; e.dbz = 1'b0;
        exp_q.push_back(e);
        @(negedge clk);
        start = 1'b0; mtlo = 1'b0;
        chk("start_mtlo_lo", lo, 64'd0);
        chk("start_mtlo_busy", busy, 64'd1);
        wait_done("start_mtlo", 0, 33);

        chk("sb_drained", exp_q.size(), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
